// File: rtl/csr_trap_pkg.sv
// Shared constants and types for the machine-mode CSR / trap unit:
// CSR addresses, mstatus/mip bit layout, interrupt codes, privilege and FSM encodings.
package csr_trap_pkg;

    localparam int CSR_OP_WIDTH = 3;

    // csr_op follows the funct3 encoding; bit 2 selects the immediate form
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_NONE = 3'b000;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_RW   = 3'b001;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_RS   = 3'b010;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_RC   = 3'b011;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_RWI  = 3'b101;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_RSI  = 3'b110;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_RCI  = 3'b111;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_TIME          = 12'hC01;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_TIMEH         = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LSB  = 11;
    localparam int MSTATUS_MPRV_BIT = 17;

    localparam logic [31:0] MSTATUS_WMASK = 32'h0002_1888;
    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

    localparam int MIP_MSIP_BIT   = 3;
    localparam int MIP_MTIP_BIT   = 7;
    localparam int MIP_MEIP_BIT   = 11;
    localparam int LOCAL_IRQ_BASE = 16;

    localparam logic [31:0] MIE_STD_MASK = 32'h0000_0888;

    localparam logic [4:0] IRQ_CODE_MSI = 5'd3;
    localparam logic [4:0] IRQ_CODE_MTI = 5'd7;
    localparam logic [4:0] IRQ_CODE_MEI = 5'd11;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_WFI = 1'b1
    } trap_state_e;

    function automatic logic [31:0] csr_wdata(input logic [CSR_OP_WIDTH-1:0] op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] rs1,
                                              input logic [4:0]  imm);
        logic [31:0] src;
        logic [31:0] res;
        src = op[2] ? {27'b0, imm} : rs1;
        case (op[1:0])
            2'b01:   res = src;
            2'b10:   res = old_val | src;
            2'b11:   res = old_val & ~src;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running wrap-around event counter with enable, shared by mcycle and minstret.
module csr_counter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/csr_irq_arbiter.sv
// Fixed-priority interrupt selector: MEI > MSI > MTI > local lines (lowest index first).
module csr_irq_arbiter
    import csr_trap_pkg::*;
(
    input  logic [31:0] pending_i,
    output logic        irq_valid_o,
    output logic [4:0]  irq_code_o
);

    logic unused_pending;
    assign unused_pending = ^{pending_i[15:12], pending_i[10:8], pending_i[6:4], pending_i[2:0]};

    // Later assignments override earlier ones, so the loop runs from lowest to highest priority
    always_comb begin
        irq_valid_o = 1'b0;
        irq_code_o  = 5'd0;
        for (int i = 31; i >= LOCAL_IRQ_BASE; i--) begin
            if (pending_i[i]) begin
                irq_valid_o = 1'b1;
                irq_code_o  = 5'(i);
            end
        end
        if (pending_i[MIP_MTIP_BIT]) begin
            irq_valid_o = 1'b1;
            irq_code_o  = IRQ_CODE_MTI;
        end
        if (pending_i[MIP_MSIP_BIT]) begin
            irq_valid_o = 1'b1;
            irq_code_o  = IRQ_CODE_MSI;
        end
        if (pending_i[MIP_MEIP_BIT]) begin
            irq_valid_o = 1'b1;
            irq_code_o  = IRQ_CODE_MEI;
        end
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/return, local interrupt bank, priority arbiter and WFI state.
// Optional mcountinhibit CSR is built when CSR_TRAP_MCOUNTINHIBIT_EN is defined.
module csr_trap_unit
    import csr_trap_pkg::*;
#(
    parameter logic [31:0] MTVEC_INIT    = 32'h0000_0000,
    parameter int unsigned NUM_LOCAL_IRQ = 16,
    parameter int unsigned CNT_WIDTH     = 64,
    localparam int unsigned LIRQ_W       = (NUM_LOCAL_IRQ == 0) ? 1 : NUM_LOCAL_IRQ
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    incr_inst_retired,
    input  logic [11:0]             csr_addr,
    input  logic [CSR_OP_WIDTH-1:0] csr_op,
    input  logic                    csr_we,
    input  logic                    csr_re,
    input  logic [31:0]             rs1_data,
    input  logic [4:0]              uimm,
    output logic [31:0]             rdata,
    output logic                    csr_access_fault,
    input  logic                    exception_event,
    input  logic [31:0]             cause,
    input  logic [31:0]             pc,
    input  logic [31:0]             badaddr,
    input  logic                    mret,
    input  logic                    wfi,
    input  logic                    instr_boundary,
    input  logic                    irq_msip,
    input  logic                    irq_mtip,
    input  logic                    irq_meip,
    input  logic [LIRQ_W-1:0]       irq_local,
    output logic                    trap_valid,
    output logic [31:0]             trap_pc,
    output logic                    wfi_stall,
    output logic [1:0]              privilege_mode,
    output logic [31:0]             mstatus,
    output logic [31:0]             mie,
    output logic [31:0]             mip
);

    localparam logic [63:0] LOCAL_ONES = (64'd1 << NUM_LOCAL_IRQ) - 64'd1;
    localparam logic [31:0] LOCAL_MASK = {LOCAL_ONES[15:0], 16'h0000};
    localparam logic [31:0] MIE_WMASK  = MIE_STD_MASK | LOCAL_MASK;

    trap_state_e state_q, state_d;
    logic [1:0]  priv_q, priv_d;
    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mip_q, mip_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic        trap_valid_q, trap_valid_d;
    logic [31:0] trap_pc_q, trap_pc_d;
    logic        wfi_stall_q;

    logic [31:0] pending;
    logic        irq_valid;
    logic [4:0]  irq_code;
    logic        irq_en;
    logic        take_exc, take_irq, take_trap, take_mret;
    logic        csr_fault, csr_commit;
    logic [31:0] csr_rval, wdata;
    logic [15:0] local_ext;
    logic        inhibit_cy, inhibit_ir;

    logic [CNT_WIDTH-1:0] cycle_cnt, instret_cnt;
    logic [63:0]          cycle_ext, instret_ext;

`ifdef CSR_TRAP_MCOUNTINHIBIT_EN
    logic [31:0] mcountinhibit_q, mcountinhibit_d;
    assign inhibit_cy = mcountinhibit_q[0];
    assign inhibit_ir = mcountinhibit_q[2];
`else
    assign inhibit_cy = 1'b0;
    assign inhibit_ir = 1'b0;
`endif

    csr_counter #(.WIDTH(CNT_WIDTH)) u_mcycle (
        .clk     (clk),
        .rst_n   (resetn),
        .en_i    (!inhibit_cy),
        .count_o (cycle_cnt)
    );

    csr_counter #(.WIDTH(CNT_WIDTH)) u_minstret (
        .clk     (clk),
        .rst_n   (resetn),
        .en_i    (incr_inst_retired && !inhibit_ir),
        .count_o (instret_cnt)
    );

    assign cycle_ext   = 64'(cycle_cnt);
    assign instret_ext = 64'(instret_cnt);

    assign local_ext = 16'(irq_local);
    assign mip_d = (32'(irq_msip) << MIP_MSIP_BIT)
                 | (32'(irq_mtip) << MIP_MTIP_BIT)
                 | (32'(irq_meip) << MIP_MEIP_BIT)
                 | ({local_ext, 16'h0000} & LOCAL_MASK);

    assign pending = mip_q & mie_q;

    csr_irq_arbiter u_arb (
        .pending_i   (pending),
        .irq_valid_o (irq_valid),
        .irq_code_o  (irq_code)
    );

    // While in WFI the core is parked between instructions, so a wake-up interrupt needs no boundary strobe
    assign irq_en    = (priv_q != PRIV_M) || mstatus_q[MSTATUS_MIE_BIT];
    assign take_exc  = exception_event;
    assign take_mret = mret && !exception_event;
    assign take_irq  = !exception_event && !mret && irq_valid && irq_en
                    && (instr_boundary || state_q == ST_WFI);
    assign take_trap = take_exc || take_irq;

    assign csr_fault = ((csr_we || csr_re) && (priv_q < csr_addr[9:8]))
                    || (csr_we && csr_addr[11:10] == 2'b11);
    assign csr_commit = csr_we && !csr_fault && !take_trap && !take_mret;

    always_comb begin
        csr_rval = 32'h0;
        case (csr_addr)
            CSR_MSTATUS:                       csr_rval = mstatus_q;
            CSR_MIE:                           csr_rval = mie_q;
            CSR_MTVEC:                         csr_rval = mtvec_q;
            CSR_MSCRATCH:                      csr_rval = mscratch_q;
            CSR_MEPC:                          csr_rval = mepc_q;
            CSR_MCAUSE:                        csr_rval = mcause_q;
            CSR_MTVAL:                         csr_rval = mtval_q;
            CSR_MIP:                           csr_rval = mip_q;
            CSR_MCYCLE, CSR_CYCLE, CSR_TIME:   csr_rval = cycle_ext[31:0];
            CSR_MCYCLEH, CSR_CYCLEH, CSR_TIMEH: csr_rval = cycle_ext[63:32];
            CSR_MINSTRET, CSR_INSTRET:         csr_rval = instret_ext[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:       csr_rval = instret_ext[63:32];
`ifdef CSR_TRAP_MCOUNTINHIBIT_EN
            CSR_MCOUNTINHIBIT:                 csr_rval = mcountinhibit_q;
`endif
            default:                           csr_rval = 32'h0;
        endcase
    end

    assign wdata            = csr_wdata(csr_op, csr_rval, rs1_data, uimm);
    assign rdata            = csr_re ? csr_rval : 32'h0;
    assign csr_access_fault = csr_fault;

    always_comb begin
        state_d      = state_q;
        priv_d       = priv_q;
        mstatus_d    = mstatus_q;
        mie_d        = mie_q;
        mtvec_d      = mtvec_q;
        mscratch_d   = mscratch_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        mtval_d      = mtval_q;
        trap_valid_d = 1'b0;
        trap_pc_d    = trap_pc_q;
`ifdef CSR_TRAP_MCOUNTINHIBIT_EN
        mcountinhibit_d = mcountinhibit_q;
`endif

        if (csr_commit) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_d = wdata & MSTATUS_WMASK;
                    // Only M and U exist; any other MPP value collapses to U
                    if (wdata[MSTATUS_MPP_LSB +: 2] != PRIV_M) begin
                        mstatus_d[MSTATUS_MPP_LSB +: 2] = PRIV_U;
                    end
                end
                CSR_MIE:      mie_d      = wdata & MIE_WMASK;
                CSR_MTVEC:    mtvec_d    = {wdata[31:2], 1'b0, wdata[0]};
                CSR_MSCRATCH: mscratch_d = wdata;
                CSR_MEPC:     mepc_d     = wdata;
                CSR_MCAUSE:   mcause_d   = wdata;
                CSR_MTVAL:    mtval_d    = wdata;
`ifdef CSR_TRAP_MCOUNTINHIBIT_EN
                CSR_MCOUNTINHIBIT: mcountinhibit_d = wdata & 32'h0000_0005;
`endif
                default: ;
            endcase
        end

        if (take_trap) begin
            mepc_d   = pc;
            mcause_d = take_exc ? cause : {1'b1, 26'b0, irq_code};
            if (take_exc) begin
                mtval_d = (badaddr == 32'hFFFF_FFFF) ? pc : badaddr;
            end else begin
                mtval_d = 32'h0;
            end
            mstatus_d[MSTATUS_MPIE_BIT]       = mstatus_q[MSTATUS_MIE_BIT];
            mstatus_d[MSTATUS_MIE_BIT]        = 1'b0;
            mstatus_d[MSTATUS_MPP_LSB +: 2]   = priv_q;
            priv_d                            = PRIV_M;
            trap_valid_d                      = 1'b1;
            trap_pc_d = {mtvec_q[31:2], 2'b00};
            if (mtvec_q[0] && take_irq) begin
                trap_pc_d = {mtvec_q[31:2], 2'b00} + {25'b0, irq_code, 2'b00};
            end
        end else if (take_mret) begin
            mstatus_d[MSTATUS_MIE_BIT]      = mstatus_q[MSTATUS_MPIE_BIT];
            mstatus_d[MSTATUS_MPIE_BIT]     = 1'b1;
            mstatus_d[MSTATUS_MPP_LSB +: 2] = PRIV_U;
            if (mstatus_q[MSTATUS_MPP_LSB +: 2] != PRIV_M) begin
                mstatus_d[MSTATUS_MPRV_BIT] = 1'b0;
            end
            priv_d       = mstatus_q[MSTATUS_MPP_LSB +: 2];
            trap_valid_d = 1'b1;
            trap_pc_d    = mepc_q;
        end

        case (state_q)
            ST_RUN: begin
                if (wfi && !exception_event && !mret && pending == 32'h0) begin
                    state_d = ST_WFI;
                end
            end
            ST_WFI: begin
                if (exception_event || pending != 32'h0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_RUN;
            priv_q       <= PRIV_M;
            mstatus_q    <= MSTATUS_RESET;
            mie_q        <= 32'h0;
            mip_q        <= 32'h0;
            mtvec_q      <= MTVEC_INIT;
            mscratch_q   <= 32'h0;
            mepc_q       <= 32'h0;
            mcause_q     <= 32'h0;
            mtval_q      <= 32'h0;
            trap_valid_q <= 1'b0;
            trap_pc_q    <= 32'h0;
            wfi_stall_q  <= 1'b0;
`ifdef CSR_TRAP_MCOUNTINHIBIT_EN
            mcountinhibit_q <= 32'h0;
`endif
        end else begin
            state_q      <= state_d;
            priv_q       <= priv_d;
            mstatus_q    <= mstatus_d;
            mie_q        <= mie_d;
            mip_q        <= mip_d;
            mtvec_q      <= mtvec_d;
            mscratch_q   <= mscratch_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            mtval_q      <= mtval_d;
            trap_valid_q <= trap_valid_d;
            trap_pc_q    <= trap_pc_d;
            wfi_stall_q  <= (state_d == ST_WFI);
`ifdef CSR_TRAP_MCOUNTINHIBIT_EN
            mcountinhibit_q <= mcountinhibit_d;
`endif
        end
    end

    assign trap_valid     = trap_valid_q;
    assign trap_pc        = trap_pc_q;
    assign wfi_stall      = wfi_stall_q;
    assign privilege_mode = priv_q;
    assign mstatus        = mstatus_q;
    assign mie            = mie_q;
    assign mip            = mip_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed self-checking bench for csr_trap_unit: traps, interrupts, mret, WFI, privilege faults, counters.
module tb_csr_trap_unit;
    import csr_trap_pkg::*;

    logic                    clk = 1'b0;
    logic                    resetn;
    logic                    incr_inst_retired;
    logic [11:0]             csr_addr;
    logic [CSR_OP_WIDTH-1:0] csr_op;
    logic                    csr_we, csr_re;
    logic [31:0]             rs1_data;
    logic [4:0]              uimm;
    logic [31:0]             rdata;
    logic                    csr_access_fault;
    logic                    exception_event;
    logic [31:0]             cause, pc, badaddr;
    logic                    mret, wfi, instr_boundary;
    logic                    irq_msip, irq_mtip, irq_meip;
    logic [15:0]             irq_local;
    logic                    trap_valid;
    logic [31:0]             trap_pc;
    logic                    wfi_stall;
    logic [1:0]              privilege_mode;
    logic [31:0]             mstatus, mie, mip;

    int n_total = 0;
    int n_bad   = 0;

    csr_trap_unit #(
        .MTVEC_INIT    (32'h0000_0080),
        .NUM_LOCAL_IRQ (16),
        .CNT_WIDTH     (64)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .incr_inst_retired (incr_inst_retired),
        .csr_addr          (csr_addr),
        .csr_op            (csr_op),
        .csr_we            (csr_we),
        .csr_re            (csr_re),
        .rs1_data          (rs1_data),
        .uimm              (uimm),
        .rdata             (rdata),
        .csr_access_fault  (csr_access_fault),
        .exception_event   (exception_event),
        .cause             (cause),
        .pc                (pc),
        .badaddr           (badaddr),
        .mret              (mret),
        .wfi               (wfi),
        .instr_boundary    (instr_boundary),
        .irq_msip          (irq_msip),
        .irq_mtip          (irq_mtip),
        .irq_meip          (irq_meip),
        .irq_local         (irq_local),
        .trap_valid        (trap_valid),
        .trap_pc           (trap_pc),
        .wfi_stall         (wfi_stall),
        .privilege_mode    (privilege_mode),
        .mstatus           (mstatus),
        .mie               (mie),
        .mip               (mip)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d,
                             output logic flt);
        @(negedge clk);
        csr_we   = 1'b1;
        csr_addr = a;
        csr_op   = op;
        rs1_data = d;
        uimm     = d[4:0];
        #1 flt   = csr_access_fault;
        @(posedge clk);
        #1 csr_we = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] v, output logic flt);
        @(negedge clk);
        csr_re   = 1'b1;
        csr_addr = a;
        #1;
        v        = rdata;
        flt      = csr_access_fault;
        csr_re   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v, v1, v2;
        logic        f;
        int          cnt;

        resetn = 1'b0; incr_inst_retired = 1'b0;
        csr_addr = '0; csr_op = CSR_OP_NONE; csr_we = 1'b0; csr_re = 1'b0;
        rs1_data = '0; uimm = '0; exception_event = 1'b0; cause = '0; pc = '0; badaddr = '0;
        mret = 1'b0; wfi = 1'b0; instr_boundary = 1'b0;
        irq_msip = 1'b0; irq_mtip = 1'b0; irq_meip = 1'b0; irq_local = '0;

        repeat (3) @(negedge clk);
        chk_eq("rst_priv", 32'(privilege_mode), 32'd3);
        chk_eq("rst_mstatus", mstatus, 32'h0000_1800);
        chk_eq("rst_mie", mie, 32'h0);
        chk_eq("rst_trap_valid", 32'(trap_valid), 32'd0);
        chk_eq("rst_trap_pc", trap_pc, 32'h0);
        chk_eq("rst_wfi_stall", 32'(wfi_stall), 32'd0);
        @(negedge clk) resetn = 1'b1;
        csr_read(CSR_MTVEC, v, f);  chk_eq("rst_mtvec", v, 32'h0000_0080);
        csr_read(CSR_MEPC, v, f);   chk_eq("rst_mepc", v, 32'h0);

        csr_write(CSR_MIE, CSR_OP_RW, 32'hFFFF_FFFF, f);
        csr_read(CSR_MIE, v, f);    chk_eq("mie_wmask", v, 32'hFFFF_0888);
        csr_write(CSR_MIE, CSR_OP_RW, 32'h0, f);
        csr_write(CSR_MIP, CSR_OP_RW, 32'hFFFF_FFFF, f);
        csr_read(CSR_MIP, v, f);    chk_eq("mip_ro", v, 32'h0);

        // synchronous exception with badaddr = all-ones
        csr_write(CSR_MTVEC, CSR_OP_RW, 32'h0000_0200, f);
        csr_write(CSR_MSTATUS, CSR_OP_RSI, 32'h8, f);
        chk_eq("mstatus_rsi", mstatus, 32'h0000_1808);
        @(negedge clk);
        pc = 32'h100; cause = 32'd2; badaddr = 32'hFFFF_FFFF; exception_event = 1'b1;
        @(negedge clk);
        exception_event = 1'b0;
        chk_eq("exc_trap_valid", 32'(trap_valid), 32'd1);
        chk_eq("exc_trap_pc", trap_pc, 32'h200);
        @(negedge clk);
        chk_eq("exc_pulse_end", 32'(trap_valid), 32'd0);
        chk_eq("exc_mstatus", mstatus, 32'h0000_1880);
        csr_read(CSR_MEPC, v, f);   chk_eq("exc_mepc", v, 32'h100);
        csr_read(CSR_MTVAL, v, f);  chk_eq("exc_mtval", v, 32'h100);
        csr_read(CSR_MCAUSE, v, f); chk_eq("exc_mcause", v, 32'd2);

        @(negedge clk) mret = 1'b1;
        @(negedge clk) mret = 1'b0;
        chk_eq("mret_valid", 32'(trap_valid), 32'd1);
        chk_eq("mret_pc", trap_pc, 32'h100);
        chk_eq("mret_mstatus", mstatus, 32'h0000_0088);
        chk_eq("mret_priv", 32'(privilege_mode), 32'd3);

        // vectored timer interrupt
        csr_write(CSR_MTVEC, CSR_OP_RW, 32'h0000_0401, f);
        csr_write(CSR_MIE, CSR_OP_RS, 32'h0000_0080, f);
        @(negedge clk); irq_mtip = 1'b1; pc = 32'h500;
        @(negedge clk);
        chk_eq("mip_mtip", mip, 32'h0000_0080);
        instr_boundary = 1'b1;
        @(negedge clk); instr_boundary = 1'b0; irq_mtip = 1'b0;
        chk_eq("mti_valid", 32'(trap_valid), 32'd1);
        chk_eq("mti_trap_pc", trap_pc, 32'h0000_041C);
        csr_read(CSR_MCAUSE, v, f); chk_eq("mti_mcause", v, 32'h8000_0007);
        csr_read(CSR_MTVAL, v, f);  chk_eq("mti_mtval", v, 32'h0);
        csr_read(CSR_MEPC, v, f);   chk_eq("mti_mepc", v, 32'h500);
        @(negedge clk) mret = 1'b1;
        @(negedge clk) mret = 1'b0;

        // arbitration: MEI over MSI over local
        csr_write(CSR_MIE, CSR_OP_RS, 32'h0001_0808, f);
        @(negedge clk); irq_meip = 1'b1; irq_msip = 1'b1; irq_local = 16'h0001; pc = 32'h600;
        @(negedge clk);
        chk_eq("mip_multi", mip, 32'h0001_0808);
        instr_boundary = 1'b1;
        @(negedge clk); instr_boundary = 1'b0;
        chk_eq("mei_valid", 32'(trap_valid), 32'd1);
        chk_eq("mei_trap_pc", trap_pc, 32'h0000_042C);
        csr_read(CSR_MCAUSE, v, f); chk_eq("mei_mcause", v, 32'h8000_000B);
        @(negedge clk); irq_meip = 1'b0; mret = 1'b1;
        @(negedge clk); mret = 1'b0;
        chk_eq("mei_mret_pc", trap_pc, 32'h600);
        @(negedge clk) instr_boundary = 1'b1;
        @(negedge clk) instr_boundary = 1'b0;
        chk_eq("msi_valid", 32'(trap_valid), 32'd1);
        chk_eq("msi_trap_pc", trap_pc, 32'h0000_040C);
        csr_read(CSR_MCAUSE, v, f); chk_eq("msi_mcause", v, 32'h8000_0003);
        @(negedge clk); irq_msip = 1'b0; irq_local = 16'h0;
        @(negedge clk);
        chk_eq("pre_wfi_mstatus", mstatus, 32'h0000_1880);

        // WFI with MIE=0: wakes on local line without taking a trap
        @(negedge clk) wfi = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wfi = 1'b0;
            if (wfi_stall) cnt++;
        end
        chk_eq("wfi_stall_cycles", 32'(cnt), 32'd5);
        irq_local = 16'h0001;
        @(negedge clk);
        chk_eq("wfi_hold", 32'(wfi_stall), 32'd1);
        @(negedge clk);
        chk_eq("wfi_wake", 32'(wfi_stall), 32'd0);
        chk_eq("wfi_no_trap0", 32'(trap_valid), 32'd0);
        @(negedge clk);
        chk_eq("wfi_no_trap1", 32'(trap_valid), 32'd0);
        irq_local = 16'h0;

        // exception beats mret and a same-cycle CSR write
        csr_write(CSR_MSCRATCH, CSR_OP_RW, 32'h0000_1234, f);
        @(negedge clk);
        exception_event = 1'b1; cause = 32'd4; pc = 32'h300; badaddr = 32'h55; mret = 1'b1;
        csr_we = 1'b1; csr_addr = CSR_MSCRATCH; csr_op = CSR_OP_RW; rs1_data = 32'hDEAD;
        @(negedge clk);
        exception_event = 1'b0; mret = 1'b0; csr_we = 1'b0;
        chk_eq("prio_valid", 32'(trap_valid), 32'd1);
        chk_eq("prio_trap_pc", trap_pc, 32'h400);
        csr_read(CSR_MSCRATCH, v, f); chk_eq("prio_mscratch", v, 32'h0000_1234);
        csr_read(CSR_MEPC, v, f);     chk_eq("prio_mepc", v, 32'h300);
        csr_read(CSR_MTVAL, v, f);    chk_eq("prio_mtval", v, 32'h55);
        chk_eq("prio_mstatus", mstatus, 32'h0000_1800);

        // drop to U mode and attempt privileged accesses
        csr_write(CSR_MSTATUS, CSR_OP_RC, 32'h0000_1800, f);
        @(negedge clk) mret = 1'b1;
        @(negedge clk) mret = 1'b0;
        chk_eq("u_priv", 32'(privilege_mode), 32'd0);
        chk_eq("u_mstatus", mstatus, 32'h0000_0080);
        csr_write(CSR_MSTATUS, CSR_OP_RW, 32'h8, f);
        chk_eq("u_wr_fault", 32'(f), 32'd1);
        chk_eq("u_mstatus_kept", mstatus, 32'h0000_0080);
        csr_read(CSR_CYCLE, v, f);    chk_eq("u_cycle_ok", 32'(f), 32'd0);
        csr_read(CSR_MSCRATCH, v, f); chk_eq("u_mscratch_fault", 32'(f), 32'd1);
        @(negedge clk); exception_event = 1'b1; cause = 32'd8; pc = 32'h700; badaddr = 32'h0;
        @(negedge clk); exception_event = 1'b0;
        chk_eq("ecall_priv", 32'(privilege_mode), 32'd3);
        chk_eq("ecall_mstatus", mstatus, 32'h0);

        // counters
        csr_read(CSR_MCYCLE, v1, f);
        repeat (2) @(negedge clk);
        csr_read(CSR_MCYCLE, v2, f);
        chk_eq("mcycle_delta", v2 - v1, 32'd3);
        csr_read(CSR_MCYCLE, v1, f);
        csr_read(CSR_TIME, v2, f);
        chk_eq("time_alias", v2 - v1, 32'd1);
        csr_read(CSR_MCYCLEH, v, f);  chk_eq("mcycleh", v, 32'h0);
        csr_read(CSR_MINSTRET, v1, f);
        @(negedge clk) incr_inst_retired = 1'b1;
        repeat (2) @(negedge clk);
        incr_inst_retired = 1'b0;
        csr_read(CSR_INSTRET, v2, f);
        chk_eq("instret_delta", v2 - v1, 32'd2);
        csr_write(CSR_CYCLE, CSR_OP_RW, 32'h0, f);
        chk_eq("ro_write_fault", 32'(f), 32'd1);
`ifdef CSR_TRAP_MCOUNTINHIBIT_EN
        csr_write(CSR_MCOUNTINHIBIT, CSR_OP_RW, 32'hFFFF_FFFF, f);
        csr_read(CSR_MCOUNTINHIBIT, v, f); chk_eq("mcountinhibit_rd", v, 32'h5);
        csr_write(CSR_MCOUNTINHIBIT, CSR_OP_RW, 32'h1, f);
        csr_read(CSR_MCYCLE, v1, f);
        repeat (2) @(negedge clk);
        csr_read(CSR_MCYCLE, v2, f);
        chk_eq("mcycle_frozen", v2 - v1, 32'd0);
        csr_write(CSR_MCOUNTINHIBIT, CSR_OP_RW, 32'h0, f);
`else
        csr_write(CSR_MCOUNTINHIBIT, CSR_OP_RW, 32'hFFFF_FFFF, f);
        csr_read(CSR_MCOUNTINHIBIT, v, f); chk_eq("mcountinhibit_rd", v, 32'h0);
        csr_read(CSR_MCYCLE, v1, f);
        repeat (2) @(negedge clk);
        csr_read(CSR_MCYCLE, v2, f);
        chk_eq("mcycle_running", v2 - v1, 32'd3);
`endif

        // reset while a trap is about to be issued
        @(negedge clk); exception_event = 1'b1; cause = 32'd5; pc = 32'h800;
        #2 resetn = 1'b0;
        @(negedge clk); exception_event = 1'b0;
        chk_eq("rst_mid_valid", 32'(trap_valid), 32'd0);
        chk_eq("rst_mid_pc", trap_pc, 32'h0);
        @(negedge clk) resetn = 1'b1;
        @(negedge clk);
        chk_eq("rst_mid_after", 32'(trap_valid), 32'd0);
        chk_eq("rst_mid_priv", 32'(privilege_mode), 32'd3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
Parametrised successor to the machine-mode CSR/exception handler. Adds a configurable bank of platform-level local interrupts, a fixed-priority interrupt arbiter and a WFI wait state, so interrupt entry is decided inside the block rather than by the core. Vectored mtvec applies only to interrupts. Sits beside the multicycle control unit and drives trap redirection of the PC.

Parameters:
- MTVEC_INIT, 32'h0000_0000: reset value of mtvec.
- NUM_LOCAL_IRQ, 16: local interrupt lines mapped to mip/mie bits 16..16+NUM_LOCAL_IRQ-1; legal range 0..16.
- CNT_WIDTH, 64: width of the cycle and instret counters; legal range 33..64.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- incr_inst_retired  in  1  instret increment strobe
- csr_addr  in  12  CSR address
- csr_op  in  CSR_OP_WIDTH  CSRRW/S/C and their I-variants
- csr_we, csr_re  in  1  write / read enables
- rs1_data  in  32  register operand
- uimm  in  5  immediate operand
- rdata  out  32  CSR read data (combinational)
- csr_access_fault  out  1  privilege violation, or write to a read-only CSR
- exception_event  in  1  synchronous exception
- cause  in  32  exception cause
- pc  in  32  PC of the current instruction
- badaddr  in  32  fault address; all-ones means use pc
- mret, wfi  in  1  instruction strobes
- instr_boundary  in  1  core is between instructions; interrupts may be taken
- irq_msip, irq_mtip, irq_meip  in  1  standard interrupt levels
- irq_local  in  NUM_LOCAL_IRQ  local interrupt levels
- trap_valid  out  1  one-cycle PC redirect pulse
- trap_pc  out  32  redirect target
- wfi_stall  out  1  core must hold in WFI
- privilege_mode  out  2  current privilege
- mstatus, mie, mip  out  32  live CSR values

Behaviour:
- Reset values:
  - privilege_mode = M; mstatus.MPP = M, all other mstatus bits 0.
  - mie, mip, mepc, mcause, mtval, mscratch = 0; mtvec = MTVEC_INIT.
  - trap_valid = 0, trap_pc = 0, wfi_stall = 0; FSM in RUN; counters = 0.
- mip bits 3/7/11 and the local bits are sampled from the input lines every cycle. They cannot be written by software; writes to mip have no effect.
- mie writable bits are 3, 7, 11 and 16..16+NUM_LOCAL_IRQ-1. All other mie bits read 0.
- Write data:
  - Set ops OR into the old value; clear ops AND-NOT from the old value; register ops use rs1_data; immediate ops use the zero-extended uimm.
  - A write is committed only when csr_we is high, csr_access_fault is 0 and no trap or mret occurs in the same cycle.
- Pending set = mip & mie.
- Interrupt enable = (privilege_mode < M) or mstatus.MIE.
- Arbiter priority: MEI(11) > MSI(3) > MTI(7) > local, lowest index first.
- Event priority within a cycle: exception > mret > interrupt (interrupt only when instr_boundary = 1) > CSR write.
- Trap entry on exception or interrupt:
  - mepc = pc; mcause = cause for exceptions, {1'b1, code} for interrupts.
  - mtval = badaddr, or pc when badaddr is all-ones; mtval = 0 for interrupts.
  - mstatus: MPIE = MIE, MIE = 0, MPP = privilege_mode; privilege_mode becomes M.
  - trap_pc = {mtvec[31:2], 2'b00}. When mtvec mode = 1 and the trap is an interrupt, add 4*code.
- mret:
  - MIE = MPIE, MPIE = 1; privilege_mode = MPP; MPP = U.
  - MPRV is cleared when MPP != M.
  - trap_pc = mepc.
- trap_valid pulses exactly one cycle, registered, one cycle after the triggering event. trap_pc is valid while trap_valid = 1.
- FSM:
  - RUN → WFI: on wfi with no pending interrupt.
  - WFI → RUN: when the pending set is non-zero, regardless of mstatus.MIE. wfi_stall = 1 only while in WFI.
  - WFI → RUN with interrupt: if interrupts are enabled on wake, the interrupt is taken in the wake cycle with mepc = pc, which the core has already advanced to WFI+4.
  - An exception while in WFI forces RUN.
- Counters:
  - mcycle increments every cycle; minstret increments on incr_inst_retired. Both wrap at 2^CNT_WIDTH.
  - time/timeh alias cycle/cycleh.
  - High halves are zero-extended when CNT_WIDTH < 64.
- Reset asserted mid-trap clears the pending trap_valid; no redirect is issued.

Optional Feature:
- Macro: CSR_TRAP_MCOUNTINHIBIT_EN.
- Defined: mcountinhibit CSR at 0x320 is implemented. Bit0 (CY) freezes mcycle; bit2 (IR) freezes minstret; all other bits read 0.
- Undefined: 0x320 reads 0, writes are ignored, and counters always run.

Decomposition:
- Package csr_trap_pkg holds:
  - CSR address constants;
  - mstatus/mip bit positions and masks;
  - interrupt cause codes;
  - the FSM state enum (RUN, WFI);
  - the privilege mode constants.
- Sub-module csr_irq_arbiter: combinational priority encoder. Inputs: pending vector. Outputs: irq_valid, irq_code[4:0].
- Reuse the existing counter module for mcycle and minstret.

Test Plan:
- Exception at pc=0x100, cause=2, badaddr=all-ones, mtvec=0x200 → trap_valid next cycle, trap_pc=0x200, mepc=0x100, mtval=0x100, MIE=0, MPIE=old MIE.
- mtvec=0x401, mie[7]=1, MIE=1, irq_mtip=1 at a boundary → mcause=0x8000_0007, trap_pc=0x41C, mtval=0.
- irq_meip, irq_msip and irq_local[0] asserted together with all enabled → mcause=0x8000_000B. Clear MEIP → 0x8000_0003 is taken next.
- wfi with MIE=0 and mie[16]=1; irq_local[0] raised after 5 cycles → wfi_stall high for 5 cycles, then low; no trap taken.
- Exception and mret asserted in the same cycle, together with a csrrw to mscratch → exception wins, mscratch unchanged, mepc=pc.
- In U mode, csrrw to mstatus → csr_access_fault=1 and mstatus unchanged. Under CSR_TRAP_MCOUNTINHIBIT_EN, mcountinhibit=1 → mcycle holds its value.
